// File: rtl/img_proc_pkg.sv
// Shared types and defaults for the image-processing pipeline blocks.
// Holds the window sequencer state encoding and window geometry helpers.
package img_proc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  localparam int DEF_IMG_WIDTH  = 512;
  localparam int DEF_IMG_HEIGHT = 512;
  localparam int DEF_PIXEL_W    = 8;
  localparam int WIN_TAPS       = 9;
  localparam int WIN_EDGE       = 2;

  // A 3x3 window ending at (row, col) lies fully inside the image only past the first two rows/cols.
  function automatic logic win_in_image(input int unsigned row, input int unsigned col);
    return (row >= 32'(WIN_EDGE)) && (col >= 32'(WIN_EDGE));
  endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// Raster position counter: tracks row/column of each accepted pixel,
// wrapping column into row and row back to zero at the end of the frame.
module pixel_pos_counter
  import img_proc_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  localparam int ROW_W = $clog2(IMG_HEIGHT),
  localparam int COL_W = $clog2(IMG_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last_pixel
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] col_r;

  // Position register: clear has priority over advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_r <= '0;
      col_r <= '0;
    end else if (clr) begin
      row_r <= '0;
      col_r <= '0;
    end else if (en) begin
      if (col_r == COL_LAST) begin
        col_r <= '0;
        row_r <= (row_r == ROW_LAST) ? '0 : row_r + ROW_W'(1);
      end else begin
        col_r <= col_r + COL_W'(1);
      end
    end
  end

  assign row        = row_r;
  assign col        = col_r;
  assign last_pixel = (row_r == ROW_LAST) && (col_r == COL_LAST);

endmodule

// File: rtl/window_sequencer.sv
// Frame sequencer for the 3x3 line buffer: gates the pixel stream, qualifies
// in-image windows and raises a level end-of-frame interrupt.
module window_sequencer
  import img_proc_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int PIXEL_W    = DEF_PIXEL_W,
  localparam int ROW_W = $clog2(IMG_HEIGHT),
  localparam int COL_W = $clog2(IMG_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               intr_clr,
  input  logic [PIXEL_W-1:0] s_pixel_data,
  input  logic               s_pixel_valid,
  output logic               s_pixel_ready,
  input  logic               m_ready,
  output logic [PIXEL_W-1:0] wg_pixel_input,
  output logic               wg_input_pixel_valid,
  output logic               wg_clear,
  output logic               win_valid,
  output logic [ROW_W-1:0]   win_row,
  output logic [COL_W-1:0]   win_col,
  output logic               busy,
  output logic               output_intr
);

  seq_state_t       state_r, state_next_s;
  logic             wg_clear_r;
  logic             win_valid_r;
  logic [ROW_W-1:0] win_row_r;
  logic [COL_W-1:0] win_col_r;
  logic             busy_r;
  logic             intr_r, intr_next_s;
  logic             start_acc_s;
  logic             ready_s;
  logic             xfer_s;
  logic             first_win_s;
  logic [ROW_W-1:0] row_s;
  logic [COL_W-1:0] col_s;
  logic             last_pixel_s;

  pixel_pos_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_pos (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_acc_s),
    .en         (xfer_s),
    .row        (row_s),
    .col        (col_s),
    .last_pixel (last_pixel_s)
  );

  // The flush cycle must not shift a pixel into the buffer being cleared.
  always_comb begin
    ready_s = 1'b0;
    if ((state_r == FILL) || (state_r == STREAM)) begin
      ready_s = m_ready && !wg_clear_r;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign xfer_s      = s_pixel_valid && ready_s;
  assign first_win_s = (row_s == ROW_W'(2)) && (col_s == COL_W'(2));

  // Next-state, start acceptance and interrupt update.
  always_comb begin
    state_next_s = state_r;
    start_acc_s  = 1'b0;
    intr_next_s  = intr_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = FILL;
          start_acc_s  = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      FILL: begin
        if (xfer_s && last_pixel_s) begin
          state_next_s = DONE;
          intr_next_s  = 1'b1;
        end else if (xfer_s && first_win_s) begin
          state_next_s = STREAM;
        end else begin
          state_next_s = FILL;
        end
      end
      STREAM: begin
        if (xfer_s && last_pixel_s) begin
          state_next_s = DONE;
          intr_next_s  = 1'b1;
        end else begin
          state_next_s = STREAM;
        end
      end
      DONE: begin
        if (start) begin
          state_next_s = FILL;
          start_acc_s  = 1'b1;
          intr_next_s  = 1'b0;
        end else if (intr_clr) begin
          state_next_s = IDLE;
          intr_next_s  = 1'b0;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
        intr_next_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; window tags share the line buffer's one-cycle latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      wg_clear_r  <= 1'b0;
      win_valid_r <= 1'b0;
      win_row_r   <= '0;
      win_col_r   <= '0;
      busy_r      <= 1'b0;
      intr_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      wg_clear_r  <= start_acc_s;
      win_valid_r <= xfer_s && win_in_image(32'(row_s), 32'(col_s));
      busy_r      <= (state_next_s == FILL) || (state_next_s == STREAM);
      intr_r      <= intr_next_s;
      if (xfer_s) begin
        win_row_r <= row_s;
        win_col_r <= col_s;
      end
    end
  end

  assign s_pixel_ready        = ready_s;
  assign wg_pixel_input       = s_pixel_data;
  assign wg_input_pixel_valid = xfer_s;
  assign wg_clear             = wg_clear_r;
  assign win_valid            = win_valid_r;
  assign win_row              = win_row_r;
  assign win_col              = win_col_r;
  assign busy                 = busy_r;
  assign output_intr          = intr_r;

endmodule

// File: tb/tb_window_sequencer.sv
// Directed bench for window_sequencer on an 8x6 image with a raster-position
// scoreboard checking every window tag against the accepted pixel stream.
module tb_window_sequencer;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk, rst, start, intr_clr, s_pixel_valid, s_pixel_ready, m_ready;
  logic [7:0] s_pixel_data, wg_pixel_input;
  logic       wg_input_pixel_valid, wg_clear, win_valid, busy, output_intr;
  logic [2:0] win_row, win_col;

  int n_cmp = 0;
  int n_bad = 0;
  int wins = 0;
  int n_xfer = 0;
  int n_clr = 0;
  int first_win_at = -1;

  // scoreboard state
  int  mr = 0, mc = 0, pr = 0, pc = 0;
  logic pend = 1'b0;
  logic exp_wv;

  window_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_W(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .intr_clr             (intr_clr),
    .s_pixel_data         (s_pixel_data),
    .s_pixel_valid        (s_pixel_valid),
    .s_pixel_ready        (s_pixel_ready),
    .m_ready              (m_ready),
    .wg_pixel_input       (wg_pixel_input),
    .wg_input_pixel_valid (wg_input_pixel_valid),
    .wg_clear             (wg_clear),
    .win_valid            (win_valid),
    .win_row              (win_row),
    .win_col              (win_col),
    .busy                 (busy),
    .output_intr          (output_intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    s_pixel_data = s_pixel_data + 8'd1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, s_pixel_ready}, 32'd0);
    chk({tag, "_wgvalid"}, {31'd0, wg_input_pixel_valid}, 32'd0);
    chk({tag, "_wgclear"}, {31'd0, wg_clear}, 32'd0);
    chk({tag, "_winvalid"}, {31'd0, win_valid}, 32'd0);
    chk({tag, "_winrow"}, {29'd0, win_row}, 32'd0);
    chk({tag, "_wincol"}, {29'd0, win_col}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_intr"}, {31'd0, output_intr}, 32'd0);
  endtask

  // start pulse from IDLE or DONE, then the one-cycle flush
  task automatic do_start(input logic with_clr);
    wins = 0; n_xfer = 0; n_clr = 0; first_win_at = -1;
    start = 1'b1; intr_clr = with_clr;
    cyc();
    start = 1'b0; intr_clr = 1'b0;
    chk("start_wgclear", {31'd0, wg_clear}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_ready", {31'd0, s_pixel_ready}, 32'd0);
    chk("start_intr", {31'd0, output_intr}, 32'd0);
    cyc();
    chk("post_clear_wgclear", {31'd0, wg_clear}, 32'd0);
  endtask

  task automatic finish_frame(input string tag);
    for (int i = 0; i < 400 && !output_intr; i++) cyc();
    chk({tag, "_intr"}, {31'd0, output_intr}, 32'd1);
    @(negedge clk); #1;
    chk({tag, "_wins"}, 32'(wins), 32'd24);
    chk({tag, "_clears"}, 32'(n_clr), 32'd1);
    chk({tag, "_ready_low"}, {31'd0, s_pixel_ready}, 32'd0);
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  // Scoreboard: the window for a transfer appears one cycle later, tagged with its raster position.
  always @(negedge clk) begin
    if (rst) begin
      mr = 0; mc = 0; pend = 1'b0;
    end else begin
      exp_wv = pend && (pr >= 2) && (pc >= 2);
      chk("win_valid", {31'd0, win_valid}, {31'd0, exp_wv});
      if (exp_wv) begin
        chk("win_row", {29'd0, win_row}, 32'(pr));
        chk("win_col", {29'd0, win_col}, 32'(pc));
        chk("intr_with_last", {31'd0, output_intr}, {31'd0, (pr == H-1) && (pc == W-1)});
      end
      if (win_valid) begin
        wins++;
        if (first_win_at < 0) first_win_at = n_xfer;
      end
      if (wg_clear) begin
        n_clr++; mr = 0; mc = 0;
      end
      pend = s_pixel_valid && s_pixel_ready;
      pr = mr; pc = mc;
      if (pend) begin
        n_xfer++;
        if (mc == W-1) begin
          mc = 0;
          mr = (mr == H-1) ? 0 : mr + 1;
        end else begin
          mc = mc + 1;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; intr_clr = 1'b0;
    s_pixel_valid = 1'b1; m_ready = 1'b1; s_pixel_data = 8'h00;
    #1;
    chk_all_zero("reset");
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("idle_ready", {31'd0, s_pixel_ready}, 32'd0);

    // full frame with source and sink always ready
    do_start(1'b0);
    chk("passthrough", {24'd0, wg_pixel_input}, {24'd0, s_pixel_data});
    chk("shift_en", {31'd0, wg_input_pixel_valid}, 32'd1);
    finish_frame("frame1");
    chk("first_win_xfer", 32'(first_win_at), 32'd19);

    // interrupt clear returns to IDLE
    intr_clr = 1'b1;
    cyc();
    intr_clr = 1'b0;
    chk("clr_intr", {31'd0, output_intr}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    cyc();
    chk("clr_idle_ready", {31'd0, s_pixel_ready}, 32'd0);
    chk("clr_idle_busy", {31'd0, busy}, 32'd0);

    // back-pressure: m_ready toggles every 3 cycles
    do_start(1'b0);
    for (int i = 0; i < 400 && !output_intr; i++) begin
      m_ready = ((i / 3) % 2) == 0;
      #1;
      chk("bp_ready_tracks", {31'd0, s_pixel_ready}, {31'd0, m_ready});
      cyc();
    end
    m_ready = 1'b1;
    finish_frame("frame_bp");

    // start and intr_clr together in DONE; start again while busy at transfer 10
    do_start(1'b1);
    for (int i = 0; i < 100 && n_xfer < 10; i++) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("busy_start_noclear", {31'd0, wg_clear}, 32'd0);
    chk("busy_start_busy", {31'd0, busy}, 32'd1);
    finish_frame("frame_ign");

    // asynchronous reset mid-frame, then a clean frame
    do_start(1'b0);
    for (int i = 0; i < 100 && n_xfer < 30; i++) cyc();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    cyc();
    rst = 1'b0;
    cyc();
    do_start(1'b0);
    finish_frame("frame_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
